// File: rtl/random_engine_host_if.sv
// Bundle of request, engine and response signals between random_engine_host and its environment.
// The slave modport is the host block itself; master is the surrounding client/engine side.
interface random_engine_host_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             req_val;
    logic             req_rdy;
    logic [CNT_W-1:0] req_count;
    logic             eng_start;
    logic             eng_stop;
    logic             eng_active;
    logic [W-1:0]     eng_rand;
    logic             resp_val;
    logic             resp_rdy;
    logic [W-1:0]     resp_data;
    logic             resp_last;
    logic             err;

    modport slave (
        input  req_val, req_count, eng_active, eng_rand, resp_rdy,
        output req_rdy, eng_start, eng_stop, resp_val, resp_data, resp_last, err
    );

    modport master (
        output req_val, req_count, eng_active, eng_rand, resp_rdy,
        input  req_rdy, eng_start, eng_stop, resp_val, resp_data, resp_last, err
    );
endinterface

// File: rtl/random_engine_host.sv
// Requests N samples from the LFSR engine, queues them in a small FIFO, returns exactly N tagged words.
// Optional macro RANDOM_HOST_DUP_CHECK_EN adds a sticky back-to-back duplicate-sample flag on err.
module random_engine_host #(
    parameter int W     = 32,
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    random_engine_host_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [W:0]       fifo_mem [DEPTH];
    logic [W:0]       head;
    logic             accept, want, push, pop;

    // want deliberately ignores eng_active: the engine derives eng_active from eng_start.
    always_comb begin
        accept      = (state_q == S_IDLE) && bus.req_val;
        want        = (state_q == S_RUN) && (remaining_q != '0) && (count_q < CW'(DEPTH));
        push        = want && bus.eng_active;
        pop         = (count_q != '0) && bus.resp_rdy;
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    remaining_d = bus.req_count;
                    if (bus.req_count != '0) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (push && (remaining_q == CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {(remaining_q == CNT_W'(1)), bus.eng_rand};
        end
    end

    assign head          = fifo_mem[rd_ptr_q];
    assign bus.req_rdy   = (state_q == S_IDLE);
    assign bus.eng_start = want;
    assign bus.eng_stop  = ~want;
    assign bus.resp_val  = (count_q != '0);
    assign bus.resp_data = head[W-1:0];
    assign bus.resp_last = (count_q != '0) && head[W];

`ifdef RANDOM_HOST_DUP_CHECK_EN
    logic [W-1:0] prev_q, prev_d;
    logic         prev_valid_q, prev_valid_d;
    logic         err_q, err_d;

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        err_d        = err_q;
        if (accept) begin
            prev_valid_d = 1'b0;
        end
        if (push) begin
            prev_d       = bus.eng_rand;
            prev_valid_d = 1'b1;
            if (prev_valid_q && (bus.eng_rand == prev_q)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_random_engine_host.sv
// Directed bench for random_engine_host with a counting engine model and a response monitor.
module tb_random_engine_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eng_en = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] rand_val = 32'h1000_0000;
    int          n_checks = 0;
    int          n_fail = 0;
    int          push_cnt = 0;
    int          start_cnt = 0;
    logic [32:0] rxq [$];

    always #5 clk = ~clk;

    random_engine_host_if #(.W(32), .CNT_W(16)) bus ();

    random_engine_host #(.W(32), .CNT_W(16), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Engine model: advances whenever started and enabled; hold forces a repeated word.
    assign bus.eng_active = bus.eng_start & eng_en;
    assign bus.eng_rand   = hold ? 32'hA5A5_A5A5 : rand_val;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.eng_active) rand_val <= rand_val + 32'd1;
            if (bus.eng_start) start_cnt <= start_cnt + 1;
            if (bus.eng_start && bus.eng_active) push_cnt <= push_cnt + 1;
            if (bus.resp_val && bus.resp_rdy) begin
                rxq.push_back({bus.resp_last, bus.resp_data});
                $display("resp data=%h last=%b", bus.resp_data, bus.resp_last);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [15:0] cnt);
        bus.req_val   = 1'b1;
        bus.req_count = cnt;
        tick(1);
        bus.req_val   = 1'b0;
    endtask

    task automatic check_words(input string tag, input int first, input int n, input logic [31:0] base);
        check({tag, " count"}, 64'(rxq.size() - first), 64'(n));
        for (int i = 0; i < n && (first + i) < rxq.size(); i++) begin
            check({tag, " data"}, 64'(rxq[first + i][31:0]), 64'(base + 32'(i)));
            check({tag, " last"}, 64'(rxq[first + i][32]), 64'(i == n - 1));
        end
    endtask

    initial begin
        logic [31:0] base;
        int          rx0, p0, s0;
        bus.req_val   = 1'b0;
        bus.req_count = '0;
        bus.resp_rdy  = 1'b1;
        tick(2);
        check("rst resp_val", 64'(bus.resp_val), 64'd0);
        check("rst req_rdy", 64'(bus.req_rdy), 64'd1);
        check("rst eng_stop", 64'(bus.eng_stop), 64'd1);
        check("rst eng_start", 64'(bus.eng_start), 64'd0);
        check("rst resp_last", 64'(bus.resp_last), 64'd0);
        check("rst err", 64'(bus.err), 64'd0);
        rst = 1'b0;
        tick(1);

        // 1: single word
        base = rand_val; rx0 = rxq.size(); s0 = start_cnt;
        request(16'd1);
        tick(1);
        check("t1 resp_val", 64'(bus.resp_val), 64'd1);
        check("t1 resp_data", 64'(bus.resp_data), 64'(base));
        check("t1 resp_last", 64'(bus.resp_last), 64'd1);
        tick(3);
        check("t1 starts", 64'(start_cnt - s0), 64'd1);
        check_words("t1", rx0, 1, base);
        check("t1 req_rdy", 64'(bus.req_rdy), 64'd1);

        // 2: backpressure fills the FIFO
        bus.resp_rdy = 1'b0;
        base = rand_val; rx0 = rxq.size(); p0 = push_cnt;
        request(16'd10);
        tick(10);
        check("t2 pushes", 64'(push_cnt - p0), 64'd4);
        check("t2 eng_stop", 64'(bus.eng_stop), 64'd1);
        check("t2 resp_val", 64'(bus.resp_val), 64'd1);
        check("t2 head", 64'(bus.resp_data), 64'(base));
        check("t2 req_rdy", 64'(bus.req_rdy), 64'd0);
        bus.resp_rdy = 1'b1;
        tick(25);
        check_words("t2", rx0, 10, base);
        check("t2 idle", 64'(bus.req_rdy), 64'd1);

        // 3: zero-length request
        rx0 = rxq.size(); s0 = start_cnt;
        request(16'd0);
        check("t3 req_rdy", 64'(bus.req_rdy), 64'd1);
        tick(4);
        check("t3 starts", 64'(start_cnt - s0), 64'd0);
        check("t3 words", 64'(rxq.size() - rx0), 64'd0);
        check("t3 resp_val", 64'(bus.resp_val), 64'd0);

        // 4: engine stalls on the 2nd and 3rd run cycles
        base = rand_val; rx0 = rxq.size(); p0 = push_cnt;
        request(16'd5);
        tick(1);
        eng_en = 1'b0;
        tick(1);
        check("t4 stall pushes", 64'(push_cnt - p0), 64'd1);
        check("t4 stall start", 64'(bus.eng_start), 64'd1);
        tick(1);
        check("t4 stall pushes2", 64'(push_cnt - p0), 64'd1);
        eng_en = 1'b1;
        tick(12);
        check_words("t4", rx0, 5, base);

        // 5: reset in the middle of a request
        bus.resp_rdy = 1'b0;
        p0 = push_cnt;
        request(16'd8);
        tick(2);
        check("t5 queued", 64'(push_cnt - p0), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5 resp_val", 64'(bus.resp_val), 64'd0);
        check("t5 eng_stop", 64'(bus.eng_stop), 64'd1);
        check("t5 req_rdy", 64'(bus.req_rdy), 64'd1);
        check("t5 resp_last", 64'(bus.resp_last), 64'd0);
        tick(1);
        rst = 1'b0;
        bus.resp_rdy = 1'b1;
        tick(1);
        base = rand_val; rx0 = rxq.size();
        request(16'd3);
        tick(8);
        check_words("t5", rx0, 3, base);

        // 6: back-to-back duplicate sample
        hold = 1'b1; rx0 = rxq.size();
        request(16'd2);
        tick(1);
        check("t6 err first", 64'(bus.err), 64'd0);
        tick(1);
`ifdef RANDOM_HOST_DUP_CHECK_EN
        check("t6 err set", 64'(bus.err), 64'd1);
        tick(5);
        check("t6 err sticky", 64'(bus.err), 64'd1);
`else
        check("t6 err set", 64'(bus.err), 64'd0);
        tick(5);
        check("t6 err sticky", 64'(bus.err), 64'd0);
`endif
        hold = 1'b0;
        check("t6 count", 64'(rxq.size() - rx0), 64'd2);
        for (int i = 0; i < 2 && (rx0 + i) < rxq.size(); i++) begin
            check("t6 data", 64'(rxq[rx0 + i][31:0]), 64'h0000_0000_A5A5_A5A5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
